// File: rtl/filter_pkg.sv
// Shared sample type, width constant and a log2 helper for the decimator slice.
package filter_pkg;

    localparam int SAMPLE_W = 8;

    typedef logic [SAMPLE_W-1:0] sample_t;

    // Ceiling log2, usable in constant expressions; clog2(1) == 0.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/filter_decimator_if.sv
// Sample-in / FIFO-head-out handshake bundle between the filter, decimator and consumer.
interface filter_decimator_if
    import filter_pkg::*;
#(
    parameter int W = SAMPLE_W
);

    logic         in_valid;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output out_valid,
        output out_data
    );

endinterface

// File: rtl/filter_dec_fifo.sv
// Register-array first-word-fall-through FIFO; head reads as zero when empty.
module filter_dec_fifo
    import filter_pkg::*;
#(
    parameter int W     = SAMPLE_W,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic                     out_valid,
    output logic [W-1:0]             out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);

    localparam int AW = clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          empty;
    logic          do_push;
    logic          do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot the push lands in.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign out_valid = ~empty;
    assign out_data  = empty ? '0 : mem[rd_ptr];
    assign count     = cnt;

endmodule

// File: rtl/filter_decimator.sv
// Decimate-by-RATIO stage feeding a small FIFO with a sticky overflow flag.
// FILTER_DEC_AVG_EN selects group averaging; otherwise the last sample of each group is kept.
module filter_decimator
    import filter_pkg::*;
#(
    parameter int W     = SAMPLE_W,
    parameter int RATIO = 2,
    parameter int DEPTH = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    filter_decimator_if.slave      bus,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);

    localparam int SH   = clog2(RATIO);
    localparam int PH_W = (SH > 0) ? SH : 1;

    logic [PH_W-1:0] phase_p0;
    logic            last_p0;
    logic            grp_done;
    logic [W-1:0]    dec_data;
    logic            pop;
    logic            full;

    assign last_p0  = (phase_p0 == PH_W'(RATIO - 1));
    assign grp_done = bus.in_valid & last_p0;
    assign pop      = bus.out_valid & bus.out_ready;

    always_ff @(posedge CLK) begin
        if (RST) begin
            phase_p0 <= '0;
        end else if (bus.in_valid) begin
            phase_p0 <= last_p0 ? '0 : phase_p0 + 1'b1;
        end
    end

`ifdef FILTER_DEC_AVG_EN
    logic [W+SH-1:0] acc_p0;
    logic [W+SH-1:0] sum;

    function automatic logic [W-1:0] avg_trunc(input logic [W+SH-1:0] s);
        return W'(s >> SH);
    endfunction

    // Group start discards the previous total so the accumulator reloads with in_data.
    always_comb begin
        sum = ((phase_p0 == '0) ? '0 : acc_p0) + (W+SH)'(bus.in_data);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            acc_p0 <= '0;
        end else if (bus.in_valid) begin
            acc_p0 <= sum;
        end
    end

    assign dec_data = avg_trunc(sum);
`else
    assign dec_data = bus.in_data;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            overflow <= 1'b0;
        end else if (grp_done & full & ~pop) begin
            overflow <= 1'b1;
        end
    end

    // ---- decimated sample -> FIFO ----
    filter_dec_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst       (RST),
        .push      (grp_done),
        .push_data (dec_data),
        .pop       (bus.out_ready),
        .out_valid (bus.out_valid),
        .out_data  (bus.out_data),
        .count     (count),
        .full      (full)
    );

endmodule

// File: tb/tb_filter_decimator.sv
// Directed bench for filter_decimator (RATIO=2, DEPTH=4); expectations follow FILTER_DEC_AVG_EN.
module tb_filter_decimator;
    import filter_pkg::*;

    localparam int W     = SAMPLE_W;
    localparam int RATIO = 2;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          CLK = 1'b0;
    logic          RST;
    logic [CW-1:0] count;
    logic          overflow;

    filter_decimator_if #(.W(W)) bus ();

    filter_decimator #(
        .W     (W),
        .RATIO (RATIO),
        .DEPTH (DEPTH)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .bus      (bus.slave),
        .count    (count),
        .overflow (overflow)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    // Expected decimated value of a two-sample group (a first, b last).
    function automatic int dec2(input int a, input int b);
`ifdef FILTER_DEC_AVG_EN
        return (a + b) / 2;
`else
        return b;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input int d);
        bus.in_valid = v;
        bus.in_data  = W'(d);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // 1. reset
        step(0, 0);
        step(0, 0);
        check("rst_out_valid", {31'd0, bus.out_valid}, 0);
        check("rst_out_data", {24'd0, bus.out_data}, 0);
        check("rst_count", {29'd0, count}, 0);
        check("rst_overflow", {31'd0, overflow}, 0);
        RST = 1'b0;

        // 2. free-running with consumer ready
        bus.out_ready = 1'b1;
        step(1, 10);
        check("t2_no_out_mid_group", {31'd0, bus.out_valid}, 0);
        step(1, 20);
        check("t2_out1_valid", {31'd0, bus.out_valid}, 1);
        check("t2_out1_data", {24'd0, bus.out_data}, dec2(10, 20));
        check("t2_out1_count", {29'd0, count}, 1);
        step(1, 30);
        check("t2_popped_valid", {31'd0, bus.out_valid}, 0);
        check("t2_empty_data", {24'd0, bus.out_data}, 0);
        step(1, 40);
        check("t2_out2_valid", {31'd0, bus.out_valid}, 1);
        check("t2_out2_data", {24'd0, bus.out_data}, dec2(30, 40));
        step(0, 0);
        check("t2_drained_count", {29'd0, count}, 0);

        // 3. stalled consumer, overflow
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) step(1, i);
        check("t3_full_count", {29'd0, count}, 4);
        check("t3_no_overflow_yet", {31'd0, overflow}, 0);
        step(1, 9);
        step(1, 10);
        check("t3_overflow", {31'd0, overflow}, 1);
        check("t3_count_held", {29'd0, count}, 4);
        step(0, 0);
        check("t3_head_stable", {24'd0, bus.out_data}, dec2(1, 2));
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3_pop%0d", i), {24'd0, bus.out_data}, dec2(2*i + 1, 2*i + 2));
            step(0, 0);
        end
        check("t3_drained_valid", {31'd0, bus.out_valid}, 0);
        check("t3_overflow_sticky", {31'd0, overflow}, 1);

        // 4. push into full FIFO with simultaneous pop
        RST = 1'b1;
        step(0, 0);
        RST = 1'b0;
        check("t4_overflow_cleared", {31'd0, overflow}, 0);
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 9; i++) step(1, i);
        check("t4_full_count", {29'd0, count}, 4);
        bus.out_ready = 1'b1;
        step(1, 10);
        check("t4_count_stays", {29'd0, count}, 4);
        check("t4_no_overflow", {31'd0, overflow}, 0);
        check("t4_oldest_popped", {24'd0, bus.out_data}, dec2(3, 4));
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t4_pop%0d", i), {24'd0, bus.out_data}, dec2(2*i + 3, 2*i + 4));
            step(0, 0);
        end
        check("t4_drained_count", {29'd0, count}, 0);

        // 5. group spanning in_valid gaps
        bus.out_ready = 1'b0;
        step(1, 8);
        step(0, 0);
        step(0, 0);
        check("t5_gap_no_output", {29'd0, count}, 0);
        step(1, 12);
        check("t5_valid", {31'd0, bus.out_valid}, 1);
        check("t5_data", {24'd0, bus.out_data}, dec2(8, 12));
        check("t5_count", {29'd0, count}, 1);

        // 6. reset mid-group with FIFO non-empty
        step(1, 99);
        RST = 1'b1;
        step(0, 0);
        RST = 1'b0;
        check("t6_rst_flush", {29'd0, count}, 0);
        step(1, 100);
        check("t6_mid_group", {31'd0, bus.out_valid}, 0);
        step(1, 200);
        check("t6_data", {24'd0, bus.out_data}, dec2(100, 200));
        check("t6_count", {29'd0, count}, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
